// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS requesters share one intercon master port.
// Optional forced termination of hung transfers when WB_ARB_TIMEOUT_EN is defined.
module wb_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_STB,
  input  logic [NUM_MASTERS-1:0]        m_WE,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_ADDR,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_DAT_I,
  output logic [DATA_W-1:0]             m_DAT_O,
  output logic [NUM_MASTERS-1:0]        m_ACK,
  output logic                          s_STB,
  output logic                          s_WE,
  output logic [ADDR_W-1:0]             s_ADDR,
  output logic [DATA_W-1:0]             s_DAT_O,
  input  logic [DATA_W-1:0]             s_DAT_I,
  input  logic                          s_ACK,
  output logic [NUM_MASTERS-1:0]        grant,
  output logic                          timeout_err
);
  localparam int LW = $clog2(NUM_MASTERS);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;

  logic [LW-1:0] gidx, last, win, idx;
  logic          done, tmo;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_RAW < 8) ? 8 : CW_RAW;
  logic [CW-1:0] cnt;
  assign tmo = (state == BUSY) && (cnt == CW'(TIMEOUT_CYCLES));
`else
  assign tmo = 1'b0;
`endif

  // Scan far-to-near from last+1 so the nearest requester overwrites the rest.
  always_comb begin
    win = '0;
    idx = '0;
    for (int off = NUM_MASTERS; off >= 1; off--) begin
      idx = LW'((int'(last) + off) % NUM_MASTERS);
      if (m_STB[idx]) win = idx;
    end
  end

  always_comb begin
    state_nx    = state;
    s_STB       = 1'b0;
    s_WE        = 1'b0;
    s_ADDR      = '0;
    s_DAT_O     = '0;
    m_ACK       = '0;
    m_DAT_O     = reset ? '0 : s_DAT_I;
    timeout_err = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: if (|m_STB) state_nx = BUSY;
      BUSY: begin
        s_STB        = m_STB[gidx];
        s_WE         = m_WE[gidx];
        s_ADDR       = m_ADDR[gidx*ADDR_W +: ADDR_W];
        s_DAT_O      = m_DAT_I[gidx*DATA_W +: DATA_W];
        m_ACK[gidx]  = s_ACK & m_STB[gidx];
        done         = s_ACK | ~m_STB[gidx];
        if (tmo) begin
          s_STB       = 1'b0;
          m_ACK[gidx] = 1'b1;
          m_DAT_O     = DATA_W'(32'hDEADBEEF);
          timeout_err = 1'b1;
          done        = 1'b1;
        end
        if (done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant <= '0;
      gidx  <= '0;
      last  <= LW'(NUM_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else if (state == IDLE && state_nx == BUSY) begin
      grant <= NUM_MASTERS'(1) << win;
      gidx  <= win;
`ifdef WB_ARB_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else if (state == BUSY && state_nx == IDLE) begin
      grant <= '0;
      last  <= gidx;
    end else if (state == BUSY) begin
`ifdef WB_ARB_TIMEOUT_EN
      cnt   <= cnt + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: per-cycle comparison against a transaction-level arbiter model,
// plus directed literal checks. Define WB_ARB_TIMEOUT_EN to also exercise forced termination.
module tb_wb_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TMO    = 8;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 255;
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  m_STB, m_WE, m_ACK, grant;
  logic [N*AW-1:0] m_ADDR;
  logic [N*DW-1:0] m_DAT_I;
  logic [DW-1:0] m_DAT_O, s_DAT_O, s_DAT_I;
  logic [AW-1:0] s_ADDR;
  logic          s_STB, s_WE, s_ACK, timeout_err;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .m_STB(m_STB), .m_WE(m_WE), .m_ADDR(m_ADDR),
    .m_DAT_I(m_DAT_I), .m_DAT_O(m_DAT_O), .m_ACK(m_ACK), .s_STB(s_STB), .s_WE(s_WE),
    .s_ADDR(s_ADDR), .s_DAT_O(s_DAT_O), .s_DAT_I(s_DAT_I), .s_ACK(s_ACK),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus, who was served last, how long the owner has waited.
  int owner, mlast, bcnt;

  function automatic int first_from(input int lst, input logic [N-1:0] stb);
    for (int off = 1; off <= N; off++)
      if (stb[(lst + off) % N]) return (lst + off) % N;
    return -1;
  endfunction

  function automatic bit stb_of(input int m);
    return m >= 0 && ((m_STB >> m) & 1) != 0;
  endfunction

  function automatic bit tmo_now();
    return TMO_EN && owner >= 0 && bcnt == TMO;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= -1;
      mlast <= N - 1;
      bcnt  <= 0;
    end else if (owner < 0) begin
      if (m_STB != '0) begin
        owner <= first_from(mlast, m_STB);
        bcnt  <= 0;
      end
    end else if (!stb_of(owner) || s_ACK || tmo_now()) begin
      mlast <= owner;
      owner <= -1;
    end else begin
      bcnt <= bcnt + 1;
    end
  end

  always @(negedge clk) begin
    check("cmp_grant", 64'(grant), owner < 0 ? 64'd0 : 64'd1 << owner);
    check("cmp_s_stb", 64'(s_STB), 64'(stb_of(owner) && !tmo_now()));
    check("cmp_s_we", 64'(s_WE), owner < 0 ? 64'd0 : 64'((m_WE >> owner) & 1));
    check("cmp_s_addr", 64'(s_ADDR), owner < 0 ? 64'd0 : 64'(AW'(m_ADDR >> (owner*AW))));
    check("cmp_s_dat", 64'(s_DAT_O), owner < 0 ? 64'd0 : 64'(DW'(m_DAT_I >> (owner*DW))));
    check("cmp_m_ack", 64'(m_ACK),
          (tmo_now() || (stb_of(owner) && s_ACK)) ? 64'd1 << owner : 64'd0);
    check("cmp_m_dat", 64'(m_DAT_O),
          tmo_now() ? 64'hDEADBEEF : (reset ? 64'd0 : 64'(s_DAT_I)));
    check("cmp_tmo", 64'(timeout_err), 64'(tmo_now()));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; m_STB = '0; m_WE = 2'b10; s_ACK = 1'b0; s_DAT_I = '0;
    m_ADDR  = {32'h0000_0200, 32'h0000_0010};
    m_DAT_I = {32'h0000_00B1, 32'h0000_00A0};
    #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_s_stb", 64'(s_STB), 64'd0);
    step; step; reset = 1'b0;

    // 1: single master read, ACK in 2nd BUSY cycle
    step; m_STB = 2'b01;
    step; #1;
    check("t1_grant", 64'(grant), 64'h1);
    check("t1_addr", 64'(s_ADDR), 64'h10);
    check("t1_stb", 64'(s_STB), 64'd1);
    step; s_ACK = 1'b1; s_DAT_I = 32'h1234_5678; #1;
    check("t1_ack", 64'(m_ACK), 64'h1);
    check("t1_dat", 64'(m_DAT_O), 64'h1234_5678);
    step; s_ACK = 1'b0; m_STB = 2'b00; #1;
    check("t1_idle", 64'(grant), 64'd0);

    // 2: simultaneous requests after reset, master 0 first
    reset = 1'b1; step; step; reset = 1'b0; m_STB = 2'b11;
    step; #1;
    check("t2_g0", 64'(grant), 64'h1);
    check("t2_a0", 64'(s_ADDR), 64'h10);
    s_ACK = 1'b1; #1;
    check("t2_ack0", 64'(m_ACK), 64'h1);
    step; s_ACK = 1'b0; m_STB = 2'b10; #1;
    check("t2_gap", 64'(grant), 64'd0);
    step; #1;
    check("t2_g1", 64'(grant), 64'h2);
    check("t2_a1", 64'(s_ADDR), 64'h200);
    check("t2_d1", 64'(s_DAT_O), 64'hB1);
    s_ACK = 1'b1; #1;
    check("t2_ack1", 64'(m_ACK), 64'h2);
    step; s_ACK = 1'b0; m_STB = 2'b11;

    // 3: continuous requests alternate 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      step; #1;
      check("t3_grant", 64'(grant), (k % 2 == 0) ? 64'h1 : 64'h2);
      s_ACK = 1'b1;
      step; s_ACK = 1'b0; #1;
      check("t3_gap", 64'(grant), 64'd0);
    end
    m_STB = 2'b00;

    // 4: master 1 aborts, late ACK ignored
    m_STB = 2'b10;
    step; #1;
    check("t4_grant", 64'(grant), 64'h2);
    step; m_STB = 2'b00; #1;
    check("t4_abort_ack", 64'(m_ACK), 64'd0);
    check("t4_abort_stb", 64'(s_STB), 64'd0);
    step; s_ACK = 1'b1; #1;
    check("t4_late_ack", 64'(m_ACK), 64'd0);
    check("t4_idle", 64'(grant), 64'd0);
    step; s_ACK = 1'b0; m_STB = 2'b01;
    step; #1;
    check("t4_next", 64'(grant), 64'h1);
    s_ACK = 1'b1;
    step; s_ACK = 1'b0; m_STB = 2'b00;

    // 5: async reset mid-BUSY
    m_STB = 2'b10;
    step; #1;
    check("t5_grant", 64'(grant), 64'h2);
    s_DAT_I = 32'hCAFE_0001; s_ACK = 1'b1; reset = 1'b1; #1;
    check("t5_stb", 64'(s_STB), 64'd0);
    check("t5_grant0", 64'(grant), 64'd0);
    check("t5_ack", 64'(m_ACK), 64'd0);
    check("t5_dat", 64'(m_DAT_O), 64'd0);
    step; step; reset = 1'b0; s_ACK = 1'b0; m_STB = 2'b11;
    step; #1;
    check("t5_first", 64'(grant), 64'h1);
    s_ACK = 1'b1;
    step; s_ACK = 1'b0; m_STB = 2'b00;

`ifdef WB_ARB_TIMEOUT_EN
    // 6: slave never ACKs
    m_STB = 2'b01;
    step;
    repeat (8) step;
    #1;
    check("t6_ack", 64'(m_ACK), 64'h1);
    check("t6_dat", 64'(m_DAT_O), 64'hDEADBEEF);
    check("t6_err", 64'(timeout_err), 64'd1);
    check("t6_stb", 64'(s_STB), 64'd0);
    step; #1;
    check("t6_idle", 64'(grant), 64'd0);
    check("t6_err_off", 64'(timeout_err), 64'd0);
    m_STB = 2'b00;
`endif

    step; step;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
